// File: rtl/seg_scan_disp.sv
// seg_scan_disp: 8-digit multiplexed 7-segment driver with cursor blink and one-pass roll
// Ports: clk/rst_n clock and async active-low reset; disp_data 8 BCD digits (digit 0 in [3:0]);
//   disp_data_en rising edge starts a roll; edit_en/weishu/shuzi cursor overlay (digit index, live value);
//   seg_sel active-low digit enables; seg_data active-low {dp,g..a}; roll_busy high while rolling.
module seg_scan_disp #(
   parameter int SCAN_DIV   = 50000,
   parameter int SCROLL_DIV = 16666666,
   parameter int BLINK_DIV  = 12500000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] disp_data,
   input  logic        disp_data_en,
   input  logic        edit_en,
   input  logic [3:0]  weishu,
   input  logic [3:0]  shuzi,
   output logic [7:0]  seg_sel,
   output logic [7:0]  seg_data,
   output logic        roll_busy
);
   localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int RCW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
   localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   typedef enum logic {ST_STATIC, ST_ROLL} state_t;
   state_t         state_q, state_d;
   logic [SCW-1:0] scan_cnt_q;
   logic [2:0]     scan_idx_q;
   logic [RCW-1:0] scroll_cnt_q;
   logic [BCW-1:0] blink_cnt_q;
   logic [31:0]    roll_reg_q;
   logic [2:0]     roll_step_q;
   logic           blink_phase_q, en_q, edit_q;
   logic [3:0]     weishu_q;
   logic [7:0]     seg_sel_q, seg_data_q, seg_data_d;
   logic [3:0]     digit;
   logic           scan_tick, roll_tick, blink_tick, blink_rst, rise, roll_start, roll_done, overlay;
   assign scan_tick  = scan_cnt_q == SCW'(SCAN_DIV - 1);
   assign roll_tick  = state_q == ST_ROLL && scroll_cnt_q == RCW'(SCROLL_DIV - 1);
   assign blink_tick = blink_cnt_q == BCW'(BLINK_DIV - 1);
   // restart the blink in the visible phase so a newly placed cursor shows at once
   assign blink_rst  = (edit_en & ~edit_q) | (weishu != weishu_q);
   assign rise       = disp_data_en & ~en_q;
   assign roll_start = state_q == ST_STATIC && rise;
   assign roll_done  = roll_tick && roll_step_q == 3'd7;
   assign seg_sel    = seg_sel_q;
   assign seg_data   = seg_data_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_STATIC;
      else        state_q <= state_d;
   end
   always_comb begin
      state_d = (state_q == ST_STATIC) ? (rise ? ST_ROLL : ST_STATIC) : (roll_done ? ST_STATIC : ST_ROLL);
   end
   always_comb begin
      roll_busy = state_q == ST_ROLL;
      overlay   = !roll_busy && edit_en && weishu == {1'b0, scan_idx_q};
      digit     = overlay ? (blink_phase_q ? shuzi : 4'hF)
                : roll_busy ? roll_reg_q[{scan_idx_q, 2'b00} +: 4] : disp_data[{scan_idx_q, 2'b00} +: 4];
   end
   always_comb begin
      case (digit)
         4'd0:    seg_data_d = 8'hC0;
         4'd1:    seg_data_d = 8'hF9;
         4'd2:    seg_data_d = 8'hA4;
         4'd3:    seg_data_d = 8'hB0;
         4'd4:    seg_data_d = 8'h99;
         4'd5:    seg_data_d = 8'h92;
         4'd6:    seg_data_d = 8'h82;
         4'd7:    seg_data_d = 8'hF8;
         4'd8:    seg_data_d = 8'h80;
         4'd9:    seg_data_d = 8'h90;
         default: seg_data_d = 8'hFF;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt_q    <= '0;
         scan_idx_q    <= '0;
         scroll_cnt_q  <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b1;
         roll_reg_q    <= '0;
         roll_step_q   <= '0;
         en_q          <= 1'b0;
         edit_q        <= 1'b0;
         weishu_q      <= '0;
         seg_sel_q     <= 8'hFF;
         seg_data_q    <= 8'hFF;
      end else begin
         scan_cnt_q    <= scan_tick ? '0 : scan_cnt_q + 1'b1;
         scan_idx_q    <= scan_idx_q + 3'(scan_tick);
         blink_cnt_q   <= (blink_rst | blink_tick) ? '0 : blink_cnt_q + 1'b1;
         blink_phase_q <= blink_rst | (blink_phase_q ^ blink_tick);
         en_q          <= disp_data_en;
         edit_q        <= edit_en;
         weishu_q      <= weishu;
         seg_sel_q     <= ~(8'h01 << scan_idx_q);
         seg_data_q    <= seg_data_d;
         if (roll_start) begin
            roll_reg_q   <= disp_data;
            roll_step_q  <= '0;
            scroll_cnt_q <= '0;
         end else if (state_q == ST_ROLL) begin
            scroll_cnt_q <= roll_tick ? '0 : scroll_cnt_q + 1'b1;
            if (roll_tick) begin
               roll_reg_q  <= {roll_reg_q[27:0], roll_reg_q[31:28]};
               roll_step_q <= roll_step_q + 3'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_seg_scan_disp.sv
// tb_seg_scan_disp: directed scoreboard bench for seg_scan_disp
module tb_seg_scan_disp;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] disp_data = '0;
   logic        disp_data_en = 1'b0;
   logic        edit_en = 1'b0;
   logic [3:0]  weishu = '0;
   logic [3:0]  shuzi = '0;
   logic [7:0]  seg_sel, seg_data;
   logic        roll_busy;
   int          n_assert = 0;
   int          n_fail = 0;
   int          cyc = 0;
   typedef struct {string tag; int idx; logic [7:0] seg;} exp_t;
   exp_t sb[$];
   seg_scan_disp #(.SCAN_DIV(4), .SCROLL_DIV(16), .BLINK_DIV(32)) dut (
      .clk(clk), .rst_n(rst_n), .disp_data(disp_data), .disp_data_en(disp_data_en),
      .edit_en(edit_en), .weishu(weishu), .shuzi(shuzi),
      .seg_sel(seg_sel), .seg_data(seg_data), .roll_busy(roll_busy)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic logic [7:0] seg_of(input logic [31:0] v, input int s);
      logic [3:0] d;
      d = v[4*s +: 4];
      case (d)
         4'd0: return 8'hC0;
         4'd1: return 8'hF9;
         4'd2: return 8'hA4;
         4'd3: return 8'hB0;
         4'd4: return 8'h99;
         4'd5: return 8'h92;
         4'd6: return 8'h82;
         4'd7: return 8'hF8;
         4'd8: return 8'h80;
         4'd9: return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction
   function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
      logic [31:0] r;
      r = v;
      for (int i = 0; i < n; i++) r = {r[27:0], r[31:28]};
      return r;
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic push(input string tag, input int idx, input logic [7:0] seg);
      exp_t e;
      e.tag = tag;
      e.idx = idx;
      e.seg = seg;
      sb.push_back(e);
   endtask
   task automatic push_num(input string tag, input logic [31:0] v, input int first, input int cnt);
      for (int k = 0; k < cnt; k++) push(tag, (first + k) % 8, seg_of(v, (first + k) % 8));
   endtask
   task automatic drain();
      exp_t e;
      logic [7:0] es;
      int n;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         es = ~(8'h01 << e.idx);
         n = 0;
         while (seg_sel !== es && n < 64) begin
            @(negedge clk);
            n++;
         end
         chk({e.tag, "_sel"}, {24'h0, seg_sel}, {24'h0, es});
         chk(e.tag, {24'h0, seg_data}, {24'h0, e.seg});
      end
   endtask
   task automatic sync0();
      int n;
      n = 0;
      while (seg_sel === 8'hFE && n < 100) begin
         @(negedge clk);
         n++;
      end
      while (seg_sel !== 8'hFE && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("sync_slot0", {31'h0, n < 100}, 32'h1);
   endtask
   initial begin
      int c0, n;
      logic [31:0] orig;
      orig = 32'h12345678;
      disp_data = orig;
      repeat (2) @(negedge clk);
      chk("rst_sel", {24'h0, seg_sel}, 32'hFF);
      chk("rst_data", {24'h0, seg_data}, 32'hFF);
      chk("rst_busy", {31'h0, roll_busy}, 32'h0);
      rst_n = 1'b1;
      push_num("s1_static", orig, 0, 8);
      drain();
      sync0();
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (seg_sel === 8'hFE && n < 20);
      chk("s1_slot_len", n, 4);
      sync0();
      edit_en = 1'b1;
      weishu = 4'd3;
      shuzi = 4'd9;
      disp_data = '0;
      for (int k = 1; k <= 19; k++)
         push("s2_blink", k % 8, (k % 8 == 3) ? ((k / 8 == 1) ? 8'hFF : 8'h90) : 8'hC0);
      drain();
      weishu = 4'd5;
      push("s2_move_other", 4, 8'hC0);
      push("s2_move_new", 5, 8'h90);
      push("s2_move_old", 3, 8'hC0);
      drain();
      edit_en = 1'b0;
      disp_data = orig;
      sync0();
      c0 = cyc;
      disp_data_en = 1'b1;
      @(negedge clk);
      chk("s3_busy_rise", {31'h0, roll_busy}, 32'h1);
      repeat (2) @(negedge clk);
      disp_data_en = 1'b0;
      for (int k = 1; k <= 8; k++)
         push("s3_roll", k % 8, seg_of((k <= 4) ? orig : rotl(orig, 1), k % 8));
      drain();
      n = 0;
      while (roll_busy === 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("s3_roll_len", cyc - c0 - 1, 128);
      push_num("s3_after", orig, 1, 8);
      drain();
      sync0();
      c0 = cyc;
      disp_data_en = 1'b1;
      @(negedge clk);
      disp_data_en = 1'b0;
      while (cyc < c0 + 40) @(negedge clk);
      disp_data_en = 1'b1;
      disp_data = '0;
      @(negedge clk);
      disp_data_en = 1'b0;
      push("s4_hold", 3, seg_of(rotl(orig, 2), 3));
      push("s4_hold", 4, seg_of(rotl(orig, 2), 4));
      drain();
      while (cyc < c0 + 128) @(negedge clk);
      chk("s4_busy_last", {31'h0, roll_busy}, 32'h1);
      disp_data_en = 1'b1;
      @(negedge clk);
      chk("s4_busy_end", {31'h0, roll_busy}, 32'h0);
      @(negedge clk);
      chk("s4_exit_rise_ignored", {31'h0, roll_busy}, 32'h0);
      disp_data_en = 1'b0;
      push_num("s4_after", 32'h0, 1, 8);
      drain();
      disp_data = 32'hABCDEF01;
      push_num("s5_blank", 32'hABCDEF01, 1, 8);
      drain();
      disp_data = orig;
      sync0();
      c0 = cyc;
      disp_data_en = 1'b1;
      @(negedge clk);
      disp_data_en = 1'b0;
      while (cyc < c0 + 50) @(negedge clk);
      chk("s6_busy_before", {31'h0, roll_busy}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk("s6_async_sel", {24'h0, seg_sel}, 32'hFF);
      chk("s6_async_data", {24'h0, seg_data}, 32'hFF);
      chk("s6_async_busy", {31'h0, roll_busy}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      push_num("s6_after", orig, 0, 8);
      drain();
      chk("s6_busy_after", {31'h0, roll_busy}, 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/seg_scan_disp.md
Name: seg_scan_disp

Overview:
- Display-side consumer of the key-entry controller's outputs (disp_data, disp_data_en, weishu, shuzi).
- Drives an 8-digit common-anode 7-segment array by time-multiplexed scanning.
- In static mode, shows the stored 8-digit number; during edit, the selected digit shows the live digit and blinks.
- A rising edge on disp_data_en starts a one-pass left rotation ("roll") of the number, one position per scroll tick, which runs to completion on its own.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot (1 kHz per digit at 50 MHz).
- SCROLL_DIV, 16666666, clk cycles per roll step (3 Hz).
- BLINK_DIV, 12500000, clk cycles per blink half-period (2 Hz blink).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- disp_data  input  32  8 BCD digits; [3:0] is digit 0 (rightmost), [31:28] is digit 7
- disp_data_en  input  1  level from the controller; its rising edge starts a roll
- edit_en  input  1  high while the controller is in input state; enables cursor overlay
- weishu  input  4  cursor digit index, 0..7
- shuzi  input  4  live digit under edit, 0..9
- seg_sel  output  8  active-low digit enables; bit i is digit i
- seg_data  output  8  active-low segments {dp,g,f,e,d,c,b,a}
- roll_busy  output  1  high while a roll is in progress

Behaviour:
- Reset (asynchronous, rst_n=0):
  - seg_sel=8'hFF, seg_data=8'hFF, roll_busy=0.
  - All counters cleared; scan_idx=0; blink_phase=1 (visible); state=STATIC.
  - A reset mid-roll aborts the roll immediately.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1. On wrap, scan_idx increments and wraps 7→0.
  - seg_sel and seg_data are registered and update together, one clk after scan_idx changes.
  - seg_sel has exactly one 0 bit, at position scan_idx, except in reset.
- Decode (dp always off, so bit7=1):
  - 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8, 8→80, 9→90.
  - Values 10..15 display blank (FF).
- Edge detect:
  - disp_data_en is registered once; rise = en & ~en_d.
- FSM, STATIC:
  - Digit i shows disp_data[4i+3:4i].
  - If edit_en=1 and i==weishu, the digit shows shuzi when blink_phase=1 and blank (FF) when blink_phase=0.
  - weishu>7 means no overlay.
  - On rise: snapshot disp_data into roll_reg, clear roll_step and scroll_cnt, go to ROLL, and set roll_busy=1 in the same edge.
- FSM, ROLL:
  - Digit i shows roll_reg[4i+3:4i]; the edit overlay is suppressed.
  - scroll_cnt counts 0..SCROLL_DIV-1. On each wrap, roll_reg rotates left by 4 bits (digit 7 moves to digit 0) and roll_step increments.
  - When the wrap occurs with roll_step==7 (8th rotation, roll_reg equals the snapshot again): go to STATIC and set roll_busy=0 on that edge.
  - rise during ROLL is ignored (no restart).
  - Changes to disp_data during ROLL do not affect the displayed data.
- Blink:
  - blink_cnt counts 0..BLINK_DIV-1; blink_phase toggles on each wrap.
  - A rising edge of edit_en, or any change of weishu, forces blink_cnt=0 and blink_phase=1, so the cursor appears immediately.
- Simultaneous events:
  - A roll tick and a scan tick on the same cycle: the displayed digit uses the pre-rotation roll_reg in that cycle and the rotated value from the next cycle.
  - rise in the same cycle as the ROLL exit: ignored; the block is in STATIC the next cycle and needs a new edge to roll again.
- Counter widths: sized by $clog2 of each divider; no overflow past DIV-1.

Test Plan:
- Use SCAN_DIV=4, SCROLL_DIV=16, BLINK_DIV=32 for all scenarios.
1. Reset, then release with disp_data=32'h12345678, edit_en=0:
   - seg_sel walks FE,FD,FB,...,7F, 4 clk each.
   - Slot 0 shows 80 ('8'); slot 7 shows F9 ('1').
2. edit_en=1, weishu=3, shuzi=9, disp_data=0:
   - Slot 3 shows 90 for 32 clk, then FF for 32 clk, repeating.
   - All other slots show C0.
   - Changing weishu to 5 immediately shows 90 in slot 5.
3. disp_data=32'h12345678, pulse disp_data_en high for 3 clk:
   - roll_busy rises; after 16 clk, slot 0 shows '1' (F9) and slot 7 shows '2' (A4).
   - After 128 clk, roll_busy=0 and the display equals the original.
4. Second disp_data_en pulse at clk 40 of a roll:
   - Ignored; the roll still ends at clk 128.
   - Changing disp_data mid-roll does not alter displayed digits until STATIC.
5. disp_data=32'hABCDEF01:
   - Slots 2..7 show FF, slot 1 shows C0, slot 0 shows F9.
6. Assert rst_n=0 at clk 50 of a roll:
   - seg_sel=FF, seg_data=FF, roll_busy=0 asynchronously.
   - After release, the block is in STATIC showing disp_data.
